// File: rtl/lm70_pkg.sv
// rtl/lm70_pkg.sv - shared constants and state encoding for the LM70 SPI reader
// Purpose: frame geometry, padding pattern, display clamp limits and FSM state codes.
// Ports: none (package).
package lm70_pkg;

  localparam int FRAME_BITS = 16;
  localparam int TEMP_BITS  = 11;
  localparam int PAD_BITS   = FRAME_BITS - TEMP_BITS;

  // The LM70 drives ones on the trailing bits; anything else means a broken frame.
  localparam logic [PAD_BITS-1:0] PAD_PATTERN = 5'b11111;

  localparam int TEMP_MIN_C = 0;
  localparam int TEMP_MAX_C = 99;

  // FSM state encoding
  typedef logic [2:0] lm70_state_t;
  localparam lm70_state_t ST_IDLE  = 3'd0;
  localparam lm70_state_t ST_SETUP = 3'd1;
  localparam lm70_state_t ST_SHIFT = 3'd2;
  localparam lm70_state_t ST_HOLD  = 3'd3;
  localparam lm70_state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/lm70_avg4.sv
// rtl/lm70_avg4.sv - 4-sample moving average of accepted LM70 readings
// Purpose: keeps the last four good readings and a running 13-bit sum.
//   avg is combinational: the average the history will hold once the
//   current sample is pushed, so the caller can register it on the same edge.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   push        commit sample into the history this cycle
//   sample      signed reading to be averaged in
//   avg         floor((sum of history including sample) / 4)
module lm70_avg4
  import lm70_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [TEMP_BITS-1:0] sample,
  output logic [TEMP_BITS-1:0] avg
);

  localparam int SUM_W = TEMP_BITS + 2;

  logic [TEMP_BITS-1:0] hist [4];
  logic [SUM_W-1:0]     sum;
  logic [SUM_W-1:0]     sum_next;
  logic [SUM_W-1:0]     sample_ext;
  logic [SUM_W-1:0]     oldest_ext;
  logic                 primed;

  assign sample_ext = {{2{sample[TEMP_BITS-1]}}, sample};
  assign oldest_ext = {{2{hist[3][TEMP_BITS-1]}}, hist[3]};

  // Until the first push, the history is treated as four copies of the sample.
  assign sum_next = primed ? (sum - oldest_ext + sample_ext) : {sample, 2'b00};

  // Dropping the two LSBs of a two's-complement sum is an arithmetic shift (floor).
  assign avg = sum_next[SUM_W-1:2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      primed <= 1'b0;
      sum    <= '0;
      for (int i = 0; i < 4; i++) hist[i] <= '0;
    end else if (push) begin
      primed <= 1'b1;
      sum    <= sum_next;
      if (!primed) begin
        for (int i = 0; i < 4; i++) hist[i] <= sample;
      end else begin
        hist[3] <= hist[2];
        hist[2] <= hist[1];
        hist[1] <= hist[0];
        hist[0] <= sample;
      end
    end
  end

endmodule

// File: rtl/lm70_spi_reader.sv
// rtl/lm70_spi_reader.sv - SPI master front-end for the LM70 temperature sensor
// Purpose: runs back-to-back 16-bit LM70 frames, checks the padding bits and
//   converts the 11-bit reading to a clamped integer degree value.
// Optional feature: define LM70_AVG4_EN to report a 4-sample moving average.
// Parameters:
//   CLK_DIV      sck half-period in clk cycles (>= 1)
//   IDLE_CYCLES  cs_n-high gap between frames in clk cycles (>= 1)
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   en            keep converting; sampled only between frames
//   sio           serial data from the sensor
//   cs_n, sck     sensor chip select (active low) and serial clock (idles low)
//   temp_raw      signed reading, 0.25 degC per LSB
//   temp_c        integer degC clamped to 0..99
//   temp_neg      sign of temp_raw
//   sample_valid  one-cycle pulse when the outputs update
//   frame_err     one-cycle pulse when a frame fails its padding check
//   busy          high whenever a frame is in progress
module lm70_spi_reader
  import lm70_pkg::*;
#(
  parameter int CLK_DIV     = 1,
  parameter int IDLE_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        sio,
  output logic        cs_n,
  output logic        sck,
  output logic [10:0] temp_raw,
  output logic [6:0]  temp_c,
  output logic        temp_neg,
  output logic        sample_valid,
  output logic        frame_err,
  output logic        busy
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int GAP_W = (IDLE_CYCLES > 1) ? $clog2(IDLE_CYCLES) : 1;
  localparam int TW    = TEMP_BITS - 2;

  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [GAP_W-1:0]    GAP_LAST = GAP_W'(IDLE_CYCLES - 1);
  localparam logic signed [TW-1:0] T_MIN   = TW'(TEMP_MIN_C);
  localparam logic signed [TW-1:0] T_MAX   = TW'(TEMP_MAX_C);

  lm70_state_t           state;
  logic [DIV_W-1:0]      div_cnt;
  logic [GAP_W-1:0]      gap_cnt;
  logic [3:0]            bit_cnt;
  logic [FRAME_BITS-1:0] shreg;

  logic                  div_last;
  logic                  frame_good;
  logic [TEMP_BITS-1:0]  raw_next;
  logic signed [TW-1:0]  t_floor;
  logic [6:0]            c_next;

  assign div_last   = (div_cnt == DIV_LAST);
  assign frame_good = (shreg[PAD_BITS-1:0] == PAD_PATTERN);
  assign busy       = (state != ST_IDLE);

`ifdef LM70_AVG4_EN
  logic                 avg_push;
  logic [TEMP_BITS-1:0] avg_raw;

  assign avg_push = (state == ST_DONE) && frame_good;

  lm70_avg4 u_avg4 (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (avg_push),
    .sample (shreg[FRAME_BITS-1:PAD_BITS]),
    .avg    (avg_raw)
  );

  assign raw_next = avg_raw;
`else
  assign raw_next = shreg[FRAME_BITS-1:PAD_BITS];
`endif

  // Dropping the two fractional bits of a two's-complement value floors it.
  assign t_floor = $signed(raw_next[TEMP_BITS-1:2]);

  always_comb begin
    c_next = 7'(TEMP_MIN_C);
    if (t_floor < T_MIN)      c_next = 7'(TEMP_MIN_C);
    else if (t_floor > T_MAX) c_next = 7'(TEMP_MAX_C);
    else                      c_next = t_floor[6:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      div_cnt      <= '0;
      gap_cnt      <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      cs_n         <= 1'b1;
      sck          <= 1'b0;
      temp_raw     <= '0;
      temp_c       <= '0;
      temp_neg     <= 1'b0;
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      frame_err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          // Gap counter saturates; a frame starts on its last gap cycle if en is high.
          if (gap_cnt == GAP_LAST) begin
            if (en) begin
              state   <= ST_SETUP;
              cs_n    <= 1'b0;
              div_cnt <= '0;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        ST_SETUP: begin
          if (div_last) begin
            state   <= ST_SHIFT;
            div_cnt <= '0;
            bit_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_SHIFT: begin
          if (div_last) begin
            div_cnt <= '0;
            if (!sck) begin
              // Rising sck: the sensor's bit has been stable for a full half-period.
              sck   <= 1'b1;
              shreg <= {shreg[FRAME_BITS-2:0], sio};
            end else begin
              sck <= 1'b0;
              if (bit_cnt == 4'd15) state <= ST_HOLD;
              else                  bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (div_last) begin
            state   <= ST_DONE;
            cs_n    <= 1'b1;
            div_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state   <= ST_IDLE;
          gap_cnt <= '0;
          if (frame_good) begin
            temp_raw     <= raw_next;
            temp_c       <= c_next;
            temp_neg     <= raw_next[TEMP_BITS-1];
            sample_valid <= 1'b1;
          end else begin
            frame_err <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          cs_n  <= 1'b1;
          sck   <= 1'b0;
        end
      endcase
    end
  end

endmodule
